// File: rtl/pwr_seq_pkg.sv
// rtl/pwr_seq_pkg.sv - Shared state encoding and helpers for the power-rail sequencer.
package pwr_seq_pkg;

  localparam int FAULT_RAIL_W = 3;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_ON        = 3'd3,
    ST_RAMP_DOWN = 3'd4,
    ST_FAULT     = 3'd5
  } pwr_state_e;

  // Index of the lowest set bit; callers only use it when some bit is set.
  function automatic logic [FAULT_RAIL_W-1:0] lowest_set(input logic [7:0] v);
    logic [FAULT_RAIL_W-1:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = i[FAULT_RAIL_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pwr_seq_ctrl_if.sv
// rtl/pwr_seq_ctrl_if.sv - Control, PMIC pin and status bundle of the power-rail sequencer.
interface pwr_seq_ctrl_if
  import pwr_seq_pkg::*;
#(
  parameter int N_RAILS = 3,
  parameter int CNT_W   = 16
);

  logic                    pwr_on_req;
  logic                    fault_clr;
  logic [CNT_W-1:0]        step_dly;
  logic [CNT_W-1:0]        pg_timeout;
  logic [N_RAILS-1:0]      rail_pg;
  logic [N_RAILS-1:0]      rail_en;
  logic                    pwr_ok;
  logic                    cpu_reset_n;
  logic                    fault;
  logic [FAULT_RAIL_W-1:0] fault_rail;
  logic [2:0]              state;

  modport master (
    output pwr_on_req, fault_clr, step_dly, pg_timeout, rail_pg,
    input  rail_en, pwr_ok, cpu_reset_n, fault, fault_rail, state
  );

  modport slave (
    input  pwr_on_req, fault_clr, step_dly, pg_timeout, rail_pg,
    output rail_en, pwr_ok, cpu_reset_n, fault, fault_rail, state
  );

endinterface

// File: rtl/pg_sync.sv
// rtl/pg_sync.sv - 2-FF power-good synchronizer with optional loss deglitch.
// Deglitch filter enabled by defining PWR_SEQ_PG_DEGLITCH_EN.
module pg_sync #(
  parameter int DG_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pg_in,
  output logic pg_s,
  output logic pg_lost
);

  logic pg_meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      pg_meta <= 1'b0;
      pg_s    <= 1'b0;
    end else begin
      pg_meta <= pg_in;
      pg_s    <= pg_meta;
    end
  end

`ifdef PWR_SEQ_PG_DEGLITCH_EN
  localparam int DW = $clog2(DG_LEN + 1);

  logic [DW-1:0] lo_cnt;

  // Run length of consecutive low samples, saturating at DG_LEN.
  always_ff @(posedge clk) begin
    if (reset) begin
      lo_cnt <= '0;
    end else if (pg_s) begin
      lo_cnt <= '0;
    end else if (lo_cnt != DW'(DG_LEN)) begin
      lo_cnt <= lo_cnt + 1'b1;
    end
  end

  assign pg_lost = (lo_cnt == DW'(DG_LEN));
`else
  logic [31:0] dg_len_unused;

  assign dg_len_unused = DG_LEN;
  assign pg_lost       = ~pg_s;
`endif

endmodule

// File: rtl/pwr_seq_ctrl.sv
// rtl/pwr_seq_ctrl.sv - Power-rail sequencer: ordered ramp-up, reverse ramp-down, fault latch.
// PWR_SEQ_PG_DEGLITCH_EN selects the filtered PG-loss detector inside pg_sync.
module pwr_seq_ctrl
  import pwr_seq_pkg::*;
#(
  parameter int N_RAILS = 3,
  parameter int CNT_W   = 16,
  parameter int DG_LEN  = 4
) (
  input  logic          clk,
  input  logic          reset,
  pwr_seq_ctrl_if.slave bus
);

  localparam int                 IDX_W    = FAULT_RAIL_W;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_RAILS - 1);
  localparam logic [N_RAILS-1:0] RAIL0    = N_RAILS'(1);

  pwr_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_RAILS-1:0] rail_en_q, rail_en_d;
  logic               cpu_rst_n_q, cpu_rst_n_d;
  logic               fault_q, fault_d;
  logic [IDX_W-1:0]   fault_rail_q, fault_rail_d;
  logic               pwr_ok_q;

  logic [N_RAILS-1:0] pg_s, pg_lost, confirmed, lost;
  logic [7:0]         pg_s8;
  logic               fault_go;
  logic [IDX_W-1:0]   fault_idx;

  for (genvar g = 0; g < N_RAILS; g++) begin : g_pg_sync
    pg_sync #(.DG_LEN(DG_LEN)) u_pg_sync (
      .clk     (clk),
      .reset   (reset),
      .pg_in   (bus.rail_pg[g]),
      .pg_s    (pg_s[g]),
      .pg_lost (pg_lost[g])
    );
  end

  // Rails whose PG has already been accepted and must stay good.
  always_comb begin
    confirmed = '0;
    for (int i = 0; i < N_RAILS; i++) begin
      if (state_q == ST_ON) begin
        confirmed[i] = 1'b1;
      end else if ((state_q == ST_RAMP_UP || state_q == ST_SETTLE) && (IDX_W'(i) < idx_q)) begin
        confirmed[i] = 1'b1;
      end
    end
  end

  assign lost    = pg_lost & confirmed;
  assign pg_s8   = 8'(pg_s);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    rail_en_d    = rail_en_q;
    cpu_rst_n_d  = cpu_rst_n_q;
    fault_d      = fault_q;
    fault_rail_d = fault_rail_q;
    fault_go     = 1'b0;
    fault_idx    = '0;

    unique case (state_q)
      ST_OFF: begin
        rail_en_d   = '0;
        cpu_rst_n_d = 1'b0;
        if (bus.pwr_on_req) begin
          state_d   = ST_RAMP_UP;
          idx_d     = '0;
          cnt_d     = '0;
          rail_en_d = RAIL0;
        end
      end
      ST_RAMP_UP: begin
        if (|lost) begin
          fault_go  = 1'b1;
          fault_idx = lowest_set(8'(lost));
        end else if (!bus.pwr_on_req) begin
          state_d = ST_RAMP_DOWN;
          cnt_d   = '0;
        end else if (pg_s8[idx_q]) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == bus.pg_timeout) begin
          fault_go  = 1'b1;
          fault_idx = idx_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_SETTLE: begin
        if (|lost) begin
          fault_go  = 1'b1;
          fault_idx = lowest_set(8'(lost));
        end else if (!bus.pwr_on_req) begin
          state_d = ST_RAMP_DOWN;
          cnt_d   = '0;
        end else if (cnt_q == bus.step_dly) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_ON;
          end else begin
            state_d   = ST_RAMP_UP;
            idx_d     = idx_q + 1'b1;
            rail_en_d = rail_en_q | (RAIL0 << (idx_q + 1'b1));
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_ON: begin
        if (|lost) begin
          fault_go  = 1'b1;
          fault_idx = lowest_set(8'(lost));
        end else if (!bus.pwr_on_req) begin
          state_d     = ST_RAMP_DOWN;
          cpu_rst_n_d = 1'b0;
          idx_d       = LAST_IDX;
          cnt_d       = '0;
        end else if (cnt_q == bus.step_dly) begin
          cpu_rst_n_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RAMP_DOWN: begin
        cpu_rst_n_d = 1'b0;
        if (cnt_q == bus.step_dly) begin
          cnt_d     = '0;
          rail_en_d = rail_en_q & ~(RAIL0 << idx_q);
          if (idx_q == '0) begin
            state_d = ST_OFF;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_FAULT: begin
        rail_en_d   = '0;
        cpu_rst_n_d = 1'b0;
        if (bus.fault_clr && !bus.pwr_on_req) begin
          state_d = ST_OFF;
          fault_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_OFF;
        rail_en_d   = '0;
        cpu_rst_n_d = 1'b0;
      end
    endcase

    // Emergency shutdown overrides whatever the state branch chose.
    if (fault_go) begin
      state_d      = ST_FAULT;
      rail_en_d    = '0;
      cpu_rst_n_d  = 1'b0;
      fault_d      = 1'b1;
      fault_rail_d = fault_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      idx_q        <= '0;
      rail_en_q    <= '0;
      cpu_rst_n_q  <= 1'b0;
      fault_q      <= 1'b0;
      fault_rail_q <= '0;
      pwr_ok_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      rail_en_q    <= rail_en_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      fault_q      <= fault_d;
      fault_rail_q <= fault_rail_d;
      pwr_ok_q     <= (state_d == ST_ON);
    end
  end

  assign bus.rail_en     = rail_en_q;
  assign bus.pwr_ok      = pwr_ok_q;
  assign bus.cpu_reset_n = cpu_rst_n_q;
  assign bus.fault       = fault_q;
  assign bus.fault_rail  = fault_rail_q;
  assign bus.state       = state_q;

endmodule
